// File: rtl/mram_pkg.sv
// Shared encodings for the MRAM sweep sequencer: engine op codes, sweep modes,
// sequencer states and data-pattern select values.
package mram_pkg;

    typedef enum logic [1:0] {
        OP_WR = 2'd0,
        OP_RD = 2'd1,
        OP_ER = 2'd2,
        OP_RS = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        MODE_WRITE = 2'd0,
        MODE_READ  = 2'd1,
        MODE_WR_RD = 2'd2,
        MODE_RESET = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_RELEASE,
        ST_WAIT_IDLE,
        ST_NEXT,
        ST_FINISH
    } state_e;

    localparam logic PAT_NORMAL  = 1'b0;
    localparam logic PAT_INVERSE = 1'b1;

    // Write-then-read mode writes on phase 0 and reads back on phase 1.
    function automatic op_e op_for(input mode_e mode, input logic phase);
        case (mode)
            MODE_WRITE: op_for = OP_WR;
            MODE_READ:  op_for = OP_RD;
            MODE_WR_RD: op_for = phase ? OP_RD : OP_WR;
            MODE_RESET: op_for = OP_RS;
            default:    op_for = OP_ER;
        endcase
    endfunction

endpackage

// File: rtl/mram_err_accum.sv
// Saturating read-error statistics: total bad bits, failing-word count and the
// address of the first failing read. Cleared at the start of every sweep.
module mram_err_accum
    import mram_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int ERRB_W = 24
) (
    input  logic              CLKM,
    input  logic              RST_N,
    input  logic              clr_i,
    input  logic              rd_valid_i,
    input  logic [15:0]       badbits_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [ADDR_W-1:0] err_words_o,
    output logic [ERRB_W-1:0] err_bits_o,
    output logic [ADDR_W-1:0] first_fail_o
);

    logic [ADDR_W-1:0] words_q, words_d;
    logic [ERRB_W-1:0] bits_q, bits_d;
    logic [ADDR_W-1:0] ff_q, ff_d;
    logic              seen_q, seen_d;
    logic [ERRB_W:0]   sum;

    always_ff @(posedge CLKM or negedge RST_N) begin
        if (!RST_N) begin
            words_q <= '0;
            bits_q  <= '0;
            ff_q    <= '1;
            seen_q  <= 1'b0;
        end else begin
            words_q <= words_d;
            bits_q  <= bits_d;
            ff_q    <= ff_d;
            seen_q  <= seen_d;
        end
    end

    always_comb begin
        words_d = words_q;
        bits_d  = bits_q;
        ff_d    = ff_q;
        seen_d  = seen_q;
        sum     = {1'b0, bits_q} + (ERRB_W+1)'(badbits_i);
        if (clr_i) begin
            words_d = '0;
            bits_d  = '0;
            ff_d    = '1;
            seen_d  = 1'b0;
        end else if (rd_valid_i && (badbits_i != 16'd0)) begin
            // The two counters saturate independently; a full bit total keeps counting words.
            bits_d = sum[ERRB_W] ? '1 : sum[ERRB_W-1:0];
            if (words_q != '1) begin
                words_d = words_q + ADDR_W'(1);
            end
            if (!seen_q) begin
                ff_d   = addr_i;
                seen_d = 1'b1;
            end
        end
    end

    assign err_words_o  = words_q;
    assign err_bits_o   = bits_q;
    assign first_fail_o = ff_q;

endmodule

// File: rtl/mram_sweep_seq.sv
// Address-sweep sequencer in front of the MRAM read/write engine.
// SWEEP_TIMEOUT_EN adds a per-op watchdog of TIMEOUT_CYC cycles.
//
//  state      | meaning
//  IDLE       | wait for a run rising edge, latch configuration
//  CHECK      | reject lo>hi (except reset op), load first address
//  ISSUE      | op/addr stable on the engine bus, start rises on exit
//  WAIT_DONE  | start held, wait for engine done, accumulate read errors
//  RELEASE    | drop start
//  WAIT_IDLE  | wait for engine done to fall
//  NEXT       | abort / phase / last-address decision
//  FINISH     | clear busy, raise done
module mram_sweep_seq
    import mram_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int ERRB_W      = 24,
    parameter int TIMEOUT_CYC = 300000
) (
    input  logic              CLKM,
    input  logic              RST_N,
    input  logic              run,
    input  logic              abort,
    input  logic [1:0]        cfg_mode,
    input  logic [ADDR_W-1:0] cfg_addr_lo,
    input  logic [ADDR_W-1:0] cfg_addr_hi,
    input  logic              cfg_inverse,
    output logic              busy,
    output logic              done,
    output logic [2:0]        status,
    output logic [ADDR_W-1:0] err_words,
    output logic [ERRB_W-1:0] err_bits,
    output logic [ADDR_W-1:0] first_fail,
    output logic              rw_start,
    output logic [1:0]        rw_oper,
    output logic [ADDR_W-1:0] rw_addr,
    output logic              rw_inverse,
    input  logic              rw_done,
    input  logic [15:0]       rw_badbits
);

    state_e            state_q, state_d;
    logic              run_prev_q;
    mode_e             mode_q, mode_d;
    logic [ADDR_W-1:0] lo_q, lo_d, hi_q, hi_d, addr_q, addr_d;
    logic              inv_q, inv_d, phase_q, phase_d;
    logic              start_q, start_d, busy_q, busy_d, done_q, done_d;
    logic              cfg_err_q, cfg_err_d, aborted_q, aborted_d;
    logic              acc_clr, rd_valid;
    op_e               cur_op;
    logic              timeout_bit;

`ifdef SWEEP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
    assign timeout_bit = timeout_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout_bit = 1'b0;
`endif

    always_ff @(posedge CLKM or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            run_prev_q <= 1'b0;
            mode_q     <= MODE_WRITE;
            lo_q       <= '0;
            hi_q       <= '0;
            addr_q     <= '0;
            inv_q      <= 1'b0;
            phase_q    <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            aborted_q  <= 1'b0;
`ifdef SWEEP_TIMEOUT_EN
            wd_q       <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            run_prev_q <= run;
            mode_q     <= mode_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            addr_q     <= addr_d;
            inv_q      <= inv_d;
            phase_q    <= phase_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            aborted_q  <= aborted_d;
`ifdef SWEEP_TIMEOUT_EN
            wd_q       <= wd_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign cur_op = op_for(mode_q, phase_q);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        addr_d    = addr_q;
        inv_d     = inv_q;
        phase_d   = phase_q;
        start_d   = start_q;
        busy_d    = busy_q;
        done_d    = done_q;
        cfg_err_d = cfg_err_q;
        aborted_d = aborted_q;
        acc_clr   = 1'b0;
        rd_valid  = 1'b0;
`ifdef SWEEP_TIMEOUT_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (run && !run_prev_q) begin
                    mode_d    = mode_e'(cfg_mode);
                    lo_d      = cfg_addr_lo;
                    hi_d      = cfg_addr_hi;
                    inv_d     = cfg_inverse;
                    acc_clr   = 1'b1;
                    cfg_err_d = 1'b0;
                    aborted_d = 1'b0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
`ifdef SWEEP_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((lo_q > hi_q) && (mode_q != MODE_RESET)) begin
                    cfg_err_d = 1'b1;
                    state_d   = ST_FINISH;
                end else begin
                    addr_d  = lo_q;
                    phase_d = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                start_d = 1'b1;
`ifdef SWEEP_TIMEOUT_EN
                wd_d    = WD_W'(TIMEOUT_CYC - 1);
`endif
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (rw_done) begin
                    rd_valid = (cur_op == OP_RD);
                    state_d  = ST_RELEASE;
                end
`ifdef SWEEP_TIMEOUT_EN
                else if (wd_q == '0) begin
                    start_d   = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_FINISH;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
`endif
            end
            ST_RELEASE: begin
                start_d = 1'b0;
                state_d = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (!rw_done) begin
                    state_d = ST_NEXT;
                end
`ifdef SWEEP_TIMEOUT_EN
                else if (wd_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FINISH;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
`endif
            end
            ST_NEXT: begin
                // hi is compared before any increment, so hi = all-ones cannot wrap.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_FINISH;
                end else if ((mode_q == MODE_WR_RD) && !phase_q) begin
                    phase_d = 1'b1;
                    state_d = ST_ISSUE;
                end else if ((mode_q == MODE_RESET) || (addr_q == hi_q)) begin
                    state_d = ST_FINISH;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    phase_d = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mram_err_accum #(
        .ADDR_W (ADDR_W),
        .ERRB_W (ERRB_W)
    ) u_err_accum (
        .CLKM         (CLKM),
        .RST_N        (RST_N),
        .clr_i        (acc_clr),
        .rd_valid_i   (rd_valid),
        .badbits_i    (rw_badbits),
        .addr_i       (addr_q),
        .err_words_o  (err_words),
        .err_bits_o   (err_bits),
        .first_fail_o (first_fail)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign status     = {timeout_bit, aborted_q, cfg_err_q};
    assign rw_start   = start_q;
    assign rw_oper    = cur_op;
    assign rw_addr    = addr_q;
    assign rw_inverse = inv_q ? PAT_INVERSE : PAT_NORMAL;

endmodule

// File: tb/tb_mram_sweep_seq.sv
// Bench for mram_sweep_seq: behavioural engine responder, directed vector table,
// randomized sweeps against a reference model, and hand-written corner sequences.
module tb_mram_sweep_seq;

    localparam int AW = 18;
    localparam int EW = 24;

    logic          CLKM = 1'b0;
    logic          RST_N;
    logic          run, abort, cfg_inverse;
    logic [1:0]    cfg_mode;
    logic [AW-1:0] cfg_addr_lo, cfg_addr_hi;
    logic          busy, done, rw_start, rw_inverse, rw_done;
    logic [2:0]    status;
    logic [AW-1:0] err_words, first_fail, rw_addr;
    logic [EW-1:0] err_bits;
    logic [1:0]    rw_oper;
    logic [15:0]   rw_badbits;

    mram_sweep_seq #(.ADDR_W(AW), .ERRB_W(EW), .TIMEOUT_CYC(50)) dut (
        .CLKM(CLKM), .RST_N(RST_N), .run(run), .abort(abort),
        .cfg_mode(cfg_mode), .cfg_addr_lo(cfg_addr_lo), .cfg_addr_hi(cfg_addr_hi),
        .cfg_inverse(cfg_inverse), .busy(busy), .done(done), .status(status),
        .err_words(err_words), .err_bits(err_bits), .first_fail(first_fail),
        .rw_start(rw_start), .rw_oper(rw_oper), .rw_addr(rw_addr),
        .rw_inverse(rw_inverse), .rw_done(rw_done), .rw_badbits(rw_badbits)
    );

    always #5 CLKM = ~CLKM;

    int cyc = 0;
    always @(posedge CLKM) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic          inv;
        int            c;
    } op_rec_t;

    op_rec_t       ops_q[$];
    op_rec_t       exp_q[$];
    logic [15:0]   bad_tab [64];
    int            eng_delay = 2;
    int            eng_rel   = 1;
    bit            eng_never = 0;

    function automatic logic [15:0] bb(input logic [AW-1:0] a);
        return bad_tab[a[5:0]];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Engine responder: accepts a start, reports done after eng_delay cycles,
    // holds done until start drops plus eng_rel cycles. Writes/resets return junk badbits.
    initial begin
        int         est, ecnt;
        logic [1:0] cur_op;
        logic [AW-1:0] cur_addr;
        rw_done = 1'b0; rw_badbits = '0; est = 0; ecnt = 0;
        cur_op = '0; cur_addr = '0;
        forever begin
            @(posedge CLKM); #1;
            case (est)
                0: if (rw_start === 1'b1 && RST_N === 1'b1) begin
                    ops_q.push_back('{rw_oper, rw_addr, rw_inverse, cyc});
                    cur_op = rw_oper; cur_addr = rw_addr; ecnt = eng_delay; est = 1;
                end
                1: if (rw_start !== 1'b1) est = 0;
                   else if (!eng_never) begin
                       if (ecnt <= 1) begin
                           rw_done = 1'b1;
                           rw_badbits = (cur_op == 2'd1) ? bb(cur_addr) : 16'hDEAD;
                           est = 2;
                       end else ecnt--;
                   end
                2: if (rw_start !== 1'b1) begin
                       if (eng_rel == 0) begin rw_done = 1'b0; rw_badbits = '0; est = 0; end
                       else begin ecnt = eng_rel; est = 3; end
                   end
                default: begin
                    ecnt--;
                    if (ecnt <= 0) begin rw_done = 1'b0; rw_badbits = '0; est = 0; end
                end
            endcase
        end
    end

    // Reference model: expected op list and statistics straight from the sweep rules.
    task automatic model(input logic [1:0] m, input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                         input logic inv, output logic [AW-1:0] w, output logic [EW-1:0] b,
                         output logic [AW-1:0] f, output logic [2:0] st);
        longint sum, nw;
        bit     found;
        exp_q.delete();
        st = 3'b000;
        if (m != 2'd3 && lo > hi) st = 3'b001;
        else if (m == 2'd3) exp_q.push_back('{2'd3, lo, inv, 0});
        else for (int a = int'(lo); a <= int'(hi); a++) begin
            if (m == 2'd0 || m == 2'd2) exp_q.push_back('{2'd0, AW'(a), inv, 0});
            if (m == 2'd1 || m == 2'd2) exp_q.push_back('{2'd1, AW'(a), inv, 0});
        end
        sum = 0; nw = 0; found = 0; f = '1;
        foreach (exp_q[i]) begin
            if (exp_q[i].op == 2'd1 && bb(exp_q[i].addr) != 0) begin
                sum += longint'(bb(exp_q[i].addr));
                nw++;
                if (!found) begin f = exp_q[i].addr; found = 1; end
            end
        end
        b = (sum > longint'(24'hFFFFFF)) ? 24'hFFFFFF : EW'(sum);
        w = (nw > longint'(18'h3FFFF)) ? 18'h3FFFF : AW'(nw);
    endtask

    task automatic cmp_ops(input string name);
        int bad_idx;
        bad_idx = -1;
        if (ops_q.size() != exp_q.size()) bad_idx = -2;
        else foreach (exp_q[i])
            if (bad_idx == -1 && (ops_q[i].op !== exp_q[i].op || ops_q[i].addr !== exp_q[i].addr
                                  || ops_q[i].inv !== exp_q[i].inv)) bad_idx = i;
        checks++;
        if (bad_idx == -2) begin
            errors++;
            $display("FAIL %s op count actual=%0d expected=%0d", name, ops_q.size(), exp_q.size());
        end else if (bad_idx >= 0) begin
            errors++;
            $display("FAIL %s op[%0d] actual=%0d@%0h inv%0b expected=%0d@%0h inv%0b", name, bad_idx,
                     ops_q[bad_idx].op, ops_q[bad_idx].addr, ops_q[bad_idx].inv,
                     exp_q[bad_idx].op, exp_q[bad_idx].addr, exp_q[bad_idx].inv);
        end
    endtask

    task automatic wait_finish(input string name, input int budget);
        int n;
        n = 0;
        while (!(done === 1'b1 && busy === 1'b0) && n < budget) begin
            @(negedge CLKM); n++;
        end
        if (n >= budget) chk({name, "_finish_budget"}, 64'(n), 64'(0));
    endtask

    task automatic do_sweep(input logic [1:0] m, input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                            input logic inv, input bit pulse_mid, output int run_c, output int done_c);
        @(negedge CLKM);
        cfg_mode = m; cfg_addr_lo = lo; cfg_addr_hi = hi; cfg_inverse = inv;
        ops_q.delete();
        run = 1'b1; run_c = cyc;
        @(negedge CLKM);
        run = 1'b0;
        chk("accept_busy", 64'(busy), 64'(1));
        chk("accept_done_clr", 64'(done), 64'(0));
        if (pulse_mid) begin
            repeat (4) @(negedge CLKM);
            run = 1'b1;
            @(negedge CLKM);
            run = 1'b0;
        end
        wait_finish("sweep", 20000);
        done_c = cyc;
        if (ops_q.size() > 0) chk("run_to_start", 64'(ops_q[0].c - run_c), 64'(3));
    endtask

    typedef struct {
        logic [1:0]       m;
        logic [AW-1:0]    lo, hi;
        logic             inv;
        logic [3:0][15:0] bad;   // badbits by addr[1:0]
        int               nops;
        logic [AW-1:0]    words;
        logic [EW-1:0]    bits;
        logic [AW-1:0]    ff;
        logic [2:0]       st;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int run_c, done_c, s, n;
        logic [AW-1:0] mw, mf, lo, hi;
        logic [EW-1:0] mb;
        logic [2:0]    mst;
        logic [1:0]    m;

        vecs[0] = '{2'd0, 18'h10, 18'h13, 1'b0, {16'd7, 16'd7, 16'd7, 16'd7}, 4, 18'd0, 24'd0, 18'h3FFFF, 3'b000};
        vecs[1] = '{2'd1, 18'h0, 18'h3, 1'b1, {16'd5, 16'd0, 16'd2, 16'd0}, 4, 18'd2, 24'd7, 18'h1, 3'b000};
        vecs[2] = '{2'd2, 18'h3FFFF, 18'h3FFFF, 1'b0, {16'd9, 16'd0, 16'd0, 16'd0}, 2, 18'd1, 24'd9, 18'h3FFFF, 3'b000};
        vecs[3] = '{2'd1, 18'h5, 18'h4, 1'b0, {16'd1, 16'd1, 16'd1, 16'd1}, 0, 18'd0, 24'd0, 18'h3FFFF, 3'b001};
        vecs[4] = '{2'd3, 18'h9, 18'h2, 1'b1, {16'd1, 16'd1, 16'd1, 16'd1}, 1, 18'd0, 24'd0, 18'h3FFFF, 3'b000};
        vecs[5] = '{2'd1, 18'h6, 18'h6, 1'b0, {16'd0, 16'd3, 16'd0, 16'd0}, 1, 18'd1, 24'd3, 18'h6, 3'b000};
        vecs[6] = '{2'd1, 18'd0, 18'd299, 1'b0, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 300, 18'd300, 24'hFFFFFF, 18'h0, 3'b000};

        RST_N = 1'b0; run = 1'b0; abort = 1'b0; cfg_mode = '0;
        cfg_addr_lo = '0; cfg_addr_hi = '0; cfg_inverse = 1'b0;
        foreach (bad_tab[i]) bad_tab[i] = '0;
        repeat (3) @(negedge CLKM);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_status", 64'(status), 64'(0));
        chk("rst_err_words", 64'(err_words), 64'(0));
        chk("rst_err_bits", 64'(err_bits), 64'(0));
        chk("rst_first_fail", 64'(first_fail), 64'(18'h3FFFF));
        chk("rst_rw_start", 64'(rw_start), 64'(0));
        chk("rst_rw_bus", 64'({rw_oper, rw_addr, rw_inverse}), 64'(0));
        RST_N = 1'b1;
        repeat (2) @(negedge CLKM);

        foreach (vecs[i]) begin
            foreach (bad_tab[k]) bad_tab[k] = vecs[i].bad[k % 4];
            eng_delay = (i == 6) ? 1 : 2 + i;
            eng_rel   = i % 3;
            do_sweep(vecs[i].m, vecs[i].lo, vecs[i].hi, vecs[i].inv, 1'b0, run_c, done_c);
            model(vecs[i].m, vecs[i].lo, vecs[i].hi, vecs[i].inv, mw, mb, mf, mst);
            chk($sformatf("vec%0d_nops", i), 64'(ops_q.size()), 64'(vecs[i].nops));
            cmp_ops($sformatf("vec%0d_ops", i));
            chk($sformatf("vec%0d_err_words", i), 64'(err_words), 64'(vecs[i].words));
            chk($sformatf("vec%0d_err_bits", i), 64'(err_bits), 64'(vecs[i].bits));
            chk($sformatf("vec%0d_first_fail", i), 64'(first_fail), 64'(vecs[i].ff));
            chk($sformatf("vec%0d_status", i), 64'(status), 64'(vecs[i].st));
            if (vecs[i].st[0]) chk($sformatf("vec%0d_cfg_err_latency_le3", i),
                                   64'(done_c - run_c <= 3), 64'(1));
        end

        for (int r = 0; r < 10; r++) begin
            foreach (bad_tab[k]) bad_tab[k] = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            m  = 2'($urandom_range(0, 3));
            lo = AW'($urandom_range(0, 18'h3FFFF));
            hi = (lo > 18'h3FFFB) ? 18'h3FFFF : lo + AW'($urandom_range(0, 4));
            if ($urandom_range(0, 4) == 0 && lo != 0) hi = lo - 1;
            eng_delay = $urandom_range(1, 6);
            eng_rel   = $urandom_range(0, 3);
            do_sweep(m, lo, hi, 1'($urandom_range(0, 1)), 1'b0, run_c, done_c);
            model(m, lo, hi, cfg_inverse, mw, mb, mf, mst);
            cmp_ops($sformatf("rnd%0d_ops", r));
            chk($sformatf("rnd%0d_err_words", r), 64'(err_words), 64'(mw));
            chk($sformatf("rnd%0d_err_bits", r), 64'(err_bits), 64'(mb));
            chk($sformatf("rnd%0d_first_fail", r), 64'(first_fail), 64'(mf));
            chk($sformatf("rnd%0d_status", r), 64'(status), 64'(mst));
        end

        // run pulse while busy must not restart the sweep
        eng_delay = 3; eng_rel = 1;
        do_sweep(2'd0, 18'd0, 18'd2, 1'b0, 1'b1, run_c, done_c);
        repeat (5) @(negedge CLKM);
        chk("busy_run_ignored_done", 64'(done), 64'(1));
        chk("busy_run_ignored_busy", 64'(busy), 64'(0));
        chk("busy_run_ignored_nops", 64'(ops_q.size()), 64'(3));

        // abort while the engine holds done
        eng_delay = 4; eng_rel = 6;
        @(negedge CLKM);
        cfg_mode = 2'd1; cfg_addr_lo = 18'h20; cfg_addr_hi = 18'h2F; cfg_inverse = 1'b0;
        ops_q.delete();
        run = 1'b1;
        @(negedge CLKM);
        run = 1'b0;
        n = 0;
        while (rw_done !== 1'b1 && n < 100) begin @(negedge CLKM); n++; end
        if (n >= 100) chk("abort_wait_done_budget", 64'(n), 64'(0));
        abort = 1'b1;
        repeat (3) @(negedge CLKM);
        chk("abort_start_low", 64'(rw_start), 64'(0));
        chk("abort_engine_done_held", 64'(rw_done), 64'(1));
        chk("abort_still_busy", 64'(busy), 64'(1));
        wait_finish("abort", 200);
        chk("abort_status", 64'(status), 64'(3'b010));
        chk("abort_nops", 64'(ops_q.size()), 64'(1));
        chk("abort_engine_idle", 64'(rw_done), 64'(0));
        abort = 1'b0;

        // reset in the middle of an op
        eng_delay = 20; eng_rel = 1;
        @(negedge CLKM);
        cfg_mode = 2'd1; cfg_addr_lo = 18'h0; cfg_addr_hi = 18'h5;
        run = 1'b1;
        @(negedge CLKM);
        run = 1'b0;
        n = 0;
        while (rw_start !== 1'b1 && n < 50) begin @(negedge CLKM); n++; end
        if (n >= 50) chk("rst_mid_wait_start_budget", 64'(n), 64'(0));
        #2 RST_N = 1'b0;
        #1;
        chk("rst_mid_start_dropped", 64'(rw_start), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_first_fail", 64'(first_fail), 64'(18'h3FFFF));
        @(negedge CLKM);
        RST_N = 1'b1;
        repeat (4) @(negedge CLKM);
        chk("rst_mid_idle_start", 64'(rw_start), 64'(0));
        chk("rst_mid_done", 64'(done), 64'(0));

`ifdef SWEEP_TIMEOUT_EN
        eng_never = 1'b1;
        @(negedge CLKM);
        cfg_mode = 2'd0; cfg_addr_lo = 18'h7; cfg_addr_hi = 18'h7;
        ops_q.delete();
        run = 1'b1;
        @(negedge CLKM);
        run = 1'b0;
        n = 0;
        while (ops_q.size() == 0 && n < 50) begin @(negedge CLKM); n++; end
        if (n >= 50) chk("tmo_wait_start_budget", 64'(n), 64'(0));
        s = (ops_q.size() > 0) ? ops_q[0].c : cyc;
        n = 0;
        while (cyc < s + 49 && n < 100) begin @(negedge CLKM); n++; end
        chk("tmo_start_held_49", 64'(rw_start), 64'(1));
        @(negedge CLKM);
        chk("tmo_start_dropped_50", 64'(rw_start), 64'(0));
        wait_finish("tmo", 20);
        chk("tmo_status", 64'(status), 64'(3'b100));
        eng_never = 1'b0;
`else
        s = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_watchdog actual=hung required=finished");
        $fatal(1);
    end

endmodule
